uart_tx_serializer: RTL
=======================

# uart_tx_serializer

Serial transmitter stage directly downstream of the colour-message UART controller. It accepts one byte at a time over the `tx_data_valid` / `tx_byte` / `o_tx_done` handshake and shifts it out on a single TX line as an asynchronous frame: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits. It holds the captured byte internally, so upstream may change `tx_byte` freely once the frame has started. A wrapping count of completed frames is provided for debug.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `PARITY_EN`, 0, 1 inserts a parity bit after D7.
- `PARITY_ODD`, 0, 0 selects even parity, 1 selects odd; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1, number of stop bits; 1 or 2.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data_valid`  in  1  byte request, level-sensitive.
- `tx_byte`  in  8  byte to send; sampled only on the accept edge.
- `o_tx_done`  out  1  high = idle and ready; low while a frame is in flight.
- `o_tx_active`  out  1  high while a frame is in flight; always the inverse of `o_tx_done`.
- `o_tx_serial`  out  1  serial line; idle level high.
- `o_frame_count`  out  8  completed frames, wraps modulo 256.

## Operation
- Reset values (at the first edge with `rst`=1): state IDLE, `o_tx_serial`=1, `o_tx_done`=1, `o_tx_active`=0, `o_frame_count`=0, bit timer 0, bit index 0.
- `rst` has priority over every other event. Reset mid-frame aborts the frame immediately: no completion and no count increment, and the line goes high on that edge.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on an edge where `tx_data_valid`=1, capture `tx_byte` into the shift register and go to START. In the same edge drive `o_tx_serial`=0, `o_tx_done`=0, `o_tx_active`=1, and clear the timer.
  - START: line 0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: line = `shift[index]` for `CLKS_PER_BIT` cycles per bit, for indices 0..7. After index 7, go to PARITY if `PARITY_EN`, else STOP.
  - PARITY: line = XOR of the 8 captured bits, XOR `PARITY_ODD`, for one bit time.
  - STOP: line 1 for `STOP_BITS`×`CLKS_PER_BIT` cycles. On the final cycle, go to IDLE, set `o_tx_done`=1, clear `o_tx_active`, and increment `o_frame_count` (255→0).
- Bit timer counts 0..`CLKS_PER_BIT`−1 and is wide enough for the parameter range (16 bits). Each bit advances on the edge where the timer equals `CLKS_PER_BIT`−1.
- `tx_data_valid` and `tx_byte` are ignored outside IDLE. Valid held high through a frame does not cause a second send of that frame. A still-high valid at the return to IDLE starts a new frame one cycle later.
- The line is glitch-free: `o_tx_serial` is driven from a register.

## Timing
- Accept latency: the start bit appears on the same edge that samples valid=1 in IDLE; `o_tx_done` falls on that edge.
- Frame length F = (1 + 8 + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles, measured from the accept edge to the edge where `o_tx_done` rises.
- `o_tx_done` stays high for at least 1 cycle between frames. Back-to-back throughput is one frame per F+1 cycles.
- Upstream compatibility: the upstream block asserts valid, waits for `o_tx_done` low, drops valid, then waits for `o_tx_done` high before the next byte. The one-cycle-minimum done-high window satisfies this.
- `o_frame_count` updates on the same edge `o_tx_done` rises.

## Test plan
- Reset behaviour (`CLKS_PER_BIT`=4): assert `rst` 3 cycles with valid=1 → `o_tx_serial`=1, `o_tx_done`=1, `o_tx_active`=0, count=0; no frame starts while in reset.
- Single byte, 8N1 (`CLKS_PER_BIT`=4): send 0x53 ('S') → line 0 for 4 cycles, then bits 1,1,0,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles. `o_tx_done` low for exactly 40 cycles; count=1.
- Full colour message: drive the 12-byte sequence "SI-SIM1-P-#" followed by 0x00 through the upstream handshake → a UART receiver model decodes all 12 bytes in order; count=12; `o_tx_done` is high for ≥1 cycle between frames.
- Parity/stop variants: `PARITY_EN`=1 with even parity, `STOP_BITS`=2, byte 0x07 → parity bit 1 and frame length 48 cycles. With odd parity, same byte → parity bit 0.
- Busy-time inputs: change `tx_byte` to 0xFF and hold valid=1 mid-frame while sending 0x00 → the transmitted bits remain 0x00. A second frame of 0xFF starts exactly 1 cycle after done rises.
- Reset mid-frame and wrap: assert `rst` during D3 → line high and done=1 on that edge, count unchanged. Separately, send 256 frames → count wraps to 0.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// Byte-wide to asynchronous serial frame transmitter: start, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits. Captures the byte on accept so upstream may move on.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_data_valid,
  input  logic [7:0] tx_byte,
  output logic       o_tx_done,
  output logic       o_tx_active,
  output logic       o_tx_serial,
  output logic [7:0] o_frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] LAST_TICK  = 16'(CLKS_PER_BIT - 1);
  localparam logic        HAS_PARITY = (PARITY_EN != 0);
  localparam logic        ODD_PARITY = (PARITY_ODD != 0);
  localparam logic        TWO_STOP   = (STOP_BITS == 2);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  index_q, index_d;
  logic [7:0]  shift_q, shift_d;
  logic        stop_q, stop_d;
  logic        serial_q, serial_d;
  logic        done_q, done_d;
  logic        active_q, active_d;
  logic [7:0]  count_q, count_d;

  logic bit_end;
  logic parity_bit;

  assign bit_end    = (timer_q == LAST_TICK);
  assign parity_bit = (^shift_q) ^ ODD_PARITY;

  always_comb begin
    state_d  = state_q;
    timer_d  = bit_end ? 16'd0 : timer_q + 16'd1;
    index_d  = index_q;
    shift_d  = shift_q;
    stop_d   = stop_q;
    serial_d = serial_q;
    done_d   = done_q;
    active_d = active_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        timer_d  = 16'd0;
        serial_d = 1'b1;
        if (tx_data_valid) begin
          // Start bit goes out on the accept edge itself.
          shift_d  = tx_byte;
          state_d  = S_START;
          serial_d = 1'b0;
          done_d   = 1'b0;
          active_d = 1'b1;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d  = S_DATA;
          index_d  = 3'd0;
          serial_d = shift_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (index_q == 3'd7) begin
            stop_d = 1'b0;
            if (HAS_PARITY) begin
              state_d  = S_PARITY;
              serial_d = parity_bit;
            end else begin
              state_d  = S_STOP;
              serial_d = 1'b1;
            end
          end else begin
            index_d  = index_q + 3'd1;
            serial_d = shift_q[index_q + 3'd1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d  = S_STOP;
          stop_d   = 1'b0;
          serial_d = 1'b1;
        end
      end

      S_STOP: begin
        serial_d = 1'b1;
        if (bit_end) begin
          // stop_q marks that the first of two stop bits has already elapsed.
          if (!TWO_STOP || stop_q) begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            active_d = 1'b0;
            count_d  = count_q + 8'd1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        serial_d = 1'b1;
        done_d   = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= 16'd0;
      index_q  <= 3'd0;
      shift_q  <= 8'd0;
      stop_q   <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b1;
      active_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      index_q  <= index_d;
      shift_q  <= shift_d;
      stop_q   <= stop_d;
      serial_q <= serial_d;
      done_q   <= done_d;
      active_q <= active_d;
      count_q  <= count_d;
    end
  end

  assign o_tx_done     = done_q;
  assign o_tx_active   = active_q;
  assign o_tx_serial   = serial_q;
  assign o_frame_count = count_q;

endmodule
